// File: rtl/game_pkg.sv
// game_pkg: shared types and widths for the game sequencer.
//   game_state_t : sequencer state, also exported to the HUD/overlay renderer
//   SCORE_W      : score width
//   WAVE_W       : wave counter width
//   sat_add      : saturating score addition
package game_pkg;

  typedef enum logic [2:0] {
    TITLE    = 3'd0,
    PLAY     = 3'd1,
    HIT      = 3'd2,
    RESPAWN  = 3'd3,
    WAVE_CLR = 3'd4,
    OVER     = 3'd5
  } game_state_t;

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned WAVE_W  = 8;

  // Sum clamps at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// game_tick_gen: game-tick divider.
//   clk   in  system clock
//   rst_n in  async active-low reset
//   clr   in  synchronous restart of the count from 0
//   tick  out high during the last cycle of every TICK_CYCLES-cycle period
module game_tick_gen #(
  parameter int unsigned TICK_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Decoded from the register only: clr is derived from the FSM next-state,
  // which itself depends on tick.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_seq_ctl.sv
// game_seq_ctl: top-level game sequencer.
//   clk, rst_n        clock, async active-low reset
//   button_shoot      start/continue button (synchronised upstream)
//   player_hit        1-cycle pulse, enemy bullet hit the player
//   alien_killed      1-cycle pulse, player bullet killed an alien
//   aliens_at_bottom  level, formation reached the player row
//   player_en/aliens_en    high only in PLAY
//   player_rst/aliens_rst  1-cycle re-init pulses, high in the first cycle of the new state
//   lives, score, wave     game counters (score saturates, wave wraps)
//   state                  current game_state_t for the overlay
module game_seq_ctl
  import game_pkg::*;
#(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned TICK_CYCLES   = 650000,
  parameter int unsigned HIT_TICKS     = 60,
  parameter int unsigned RESPAWN_TICKS = 40,
  parameter int unsigned ALIENS_TOTAL  = 55,
  parameter int unsigned POINTS        = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               button_shoot,
  input  logic               player_hit,
  input  logic               alien_killed,
  input  logic               aliens_at_bottom,
  output logic               player_en,
  output logic               player_rst,
  output logic               aliens_en,
  output logic               aliens_rst,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [WAVE_W-1:0]  wave,
  output logic [2:0]         state
);

  localparam int unsigned TMAX = (HIT_TICKS > RESPAWN_TICKS) ? HIT_TICKS : RESPAWN_TICKS;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  // One extra count of headroom: a kill in the cycle the total is seen can push past it.
  localparam int unsigned KW   = $clog2(ALIENS_TOTAL + 2);
  localparam logic [SCORE_W-1:0] PTS       = SCORE_W'(POINTS);
  localparam logic [TW-1:0]      HIT_LAST  = TW'(HIT_TICKS - 1);
  localparam logic [TW-1:0]      RESP_LAST = TW'(RESPAWN_TICKS - 1);

  game_state_t        state_r, state_nxt;
  logic               btn_d;
  logic               start;
  logic               tick;
  logic               clr;
  logic [KW-1:0]      kills_r, kills_nxt;
  logic [TW-1:0]      ticks_r, ticks_nxt;
  logic [2:0]         lives_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [WAVE_W-1:0]  wave_nxt;
  logic               prst_nxt, arst_nxt;

  assign start = button_shoot & ~btn_d;
  assign state = state_r;

  game_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state_r;
    lives_nxt = lives;
    score_nxt = score;
    wave_nxt  = wave;
    kills_nxt = kills_r;
    ticks_nxt = ticks_r;
    prst_nxt  = 1'b0;
    arst_nxt  = 1'b0;
    case (state_r)
      TITLE: begin
        if (start) begin
          state_nxt = PLAY;
          lives_nxt = 3'(LIVES);
          score_nxt = '0;
          wave_nxt  = '0;
          kills_nxt = '0;
          prst_nxt  = 1'b1;
          arst_nxt  = 1'b1;
        end
      end
      PLAY: begin
        if (alien_killed) begin
          score_nxt = sat_add(score, PTS);
          kills_nxt = kills_r + KW'(1);
        end
        if (aliens_at_bottom) begin
          state_nxt = OVER;
          lives_nxt = '0;
        end else if (player_hit) begin
          state_nxt = HIT;
          lives_nxt = (lives != '0) ? lives - 3'd1 : '0;
        end else if (kills_r >= KW'(ALIENS_TOTAL)) begin
          state_nxt = WAVE_CLR;
        end
      end
      HIT: begin
        if (tick) begin
          if (ticks_r == HIT_LAST) begin
            state_nxt = (lives == '0) ? OVER : RESPAWN;
            prst_nxt  = (lives != '0);
          end else begin
            ticks_nxt = ticks_r + TW'(1);
          end
        end
      end
      RESPAWN: begin
        if (tick) begin
          if (ticks_r == RESP_LAST) state_nxt = PLAY;
          else                      ticks_nxt = ticks_r + TW'(1);
        end
      end
      WAVE_CLR: begin
        if (tick) begin
          if (ticks_r == RESP_LAST) begin
            state_nxt = PLAY;
            kills_nxt = '0;
            wave_nxt  = wave + WAVE_W'(1);
            prst_nxt  = 1'b1;
            arst_nxt  = 1'b1;
          end else begin
            ticks_nxt = ticks_r + TW'(1);
          end
        end
      end
      OVER: begin
        if (start) state_nxt = TITLE;
      end
      default: state_nxt = TITLE;
    endcase
    // Every state change restarts both the cycle divider and the tick count.
    if (state_nxt != state_r) ticks_nxt = '0;
  end

  assign clr = (state_nxt != state_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= TITLE;
      btn_d      <= 1'b0;
      kills_r    <= '0;
      ticks_r    <= '0;
      lives      <= '0;
      score      <= '0;
      wave       <= '0;
      player_en  <= 1'b0;
      aliens_en  <= 1'b0;
      player_rst <= 1'b0;
      aliens_rst <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      btn_d      <= button_shoot;
      kills_r    <= kills_nxt;
      ticks_r    <= ticks_nxt;
      lives      <= lives_nxt;
      score      <= score_nxt;
      wave       <= wave_nxt;
      player_en  <= (state_nxt == PLAY);
      aliens_en  <= (state_nxt == PLAY);
      player_rst <= prst_nxt;
      aliens_rst <= arst_nxt;
    end
  end

endmodule

// File: tb/tb_game_seq_ctl.sv
// tb_game_seq_ctl: directed bench for game_seq_ctl with short timers.
module tb_game_seq_ctl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic button_shoot = 1'b0, player_hit = 1'b0, alien_killed = 1'b0, aliens_at_bottom = 1'b0;
  logic player_en, player_rst, aliens_en, aliens_rst;
  logic [2:0] lives;
  logic [15:0] score;
  logic [7:0] wave;
  logic [2:0] state;

  // Second instance with a large point value to reach score saturation quickly.
  logic btn2 = 1'b0, kill2 = 1'b0;
  logic pen2, prst2, aen2, arst2;
  logic [2:0] lives2;
  logic [15:0] score2;
  logic [7:0] wave2;
  logic [2:0] state2;

  int total = 0;
  int bad = 0;
  int prst_cnt = 0, arst_cnt = 0, wide_cnt = 0;
  logic prst_prev = 1'b0, arst_prev = 1'b0;

  always #5 clk = ~clk;

  game_seq_ctl #(
    .LIVES(2), .TICK_CYCLES(4), .HIT_TICKS(3), .RESPAWN_TICKS(2),
    .ALIENS_TOTAL(3), .POINTS(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button_shoot(button_shoot), .player_hit(player_hit),
    .alien_killed(alien_killed), .aliens_at_bottom(aliens_at_bottom),
    .player_en(player_en), .player_rst(player_rst), .aliens_en(aliens_en),
    .aliens_rst(aliens_rst), .lives(lives), .score(score), .wave(wave), .state(state)
  );

  game_seq_ctl #(
    .LIVES(2), .TICK_CYCLES(4), .HIT_TICKS(3), .RESPAWN_TICKS(2),
    .ALIENS_TOTAL(10), .POINTS(16'hFFF0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .button_shoot(btn2), .player_hit(1'b0),
    .alien_killed(kill2), .aliens_at_bottom(1'b0),
    .player_en(pen2), .player_rst(prst2), .aliens_en(aen2),
    .aliens_rst(arst2), .lives(lives2), .score(score2), .wave(wave2), .state(state2)
  );

  always @(negedge clk) begin
    if (player_rst) prst_cnt <= prst_cnt + 1;
    if (aliens_rst) arst_cnt <= arst_cnt + 1;
    if ((player_rst && prst_prev) || (aliens_rst && arst_prev)) wide_cnt <= wide_cnt + 1;
    prst_prev <= player_rst;
    arst_prev <= aliens_rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input string tag, input logic [2:0] target);
    int k = 0;
    while (state != target && k < 200) begin
      k++;
      step();
    end
    check(tag, {29'd0, state}, {29'd0, target});
  endtask

  task automatic measure(input logic [2:0] target, output int n);
    n = 0;
    while (state == target && n < 500) begin
      n++;
      step();
    end
  endtask

  task automatic press();
    button_shoot = 1'b1;
    step();
    button_shoot = 1'b0;
    step();
  endtask

  task automatic kill();
    alien_killed = 1'b1;
    step();
    alien_killed = 1'b0;
    step();
  endtask

  initial begin
    int n, p0, a0, starts;
    logic [2:0] prev;

    #3 rst_n = 1'b0;
    repeat (3) step();
    check("rst_state", state, TITLE);
    check("rst_lives", lives, 0);
    check("rst_score", score, 0);
    check("rst_wave", wave, 0);
    check("rst_en", {player_en, aliens_en, player_rst, aliens_rst}, 0);
    rst_n = 1'b1;
    step();

    // 1: held button starts exactly once
    p0 = prst_cnt; a0 = arst_cnt; starts = 0;
    button_shoot = 1'b1;
    prev = state;
    for (int i = 0; i < 20; i++) begin
      step();
      if (prev == TITLE && state == PLAY) starts++;
      prev = state;
    end
    button_shoot = 1'b0;
    check("t1_starts", starts, 1);
    check("t1_state", state, PLAY);
    check("t1_lives", lives, 2);
    check("t1_score", score, 0);
    check("t1_en", {player_en, aliens_en}, 2'b11);
    check("t1_prst", prst_cnt - p0, 1);
    check("t1_arst", arst_cnt - a0, 1);

    // 2: wave clear
    p0 = prst_cnt; a0 = arst_cnt;
    kill(); kill(); kill();
    check("t2_score", score, 30);
    wait_for("t2_enter_wclr", WAVE_CLR);
    check("t2_en_off", {player_en, aliens_en}, 0);
    measure(WAVE_CLR, n);
    check("t2_wclr_len", n, 8);
    check("t2_back_play", state, PLAY);
    check("t2_wave", wave, 1);
    step();
    check("t2_prst", prst_cnt - p0, 1);
    check("t2_arst", arst_cnt - a0, 1);

    // 3: hit, respawn, then game over
    p0 = prst_cnt; a0 = arst_cnt;
    player_hit = 1'b1; step(); player_hit = 1'b0;
    check("t3_hit", state, HIT);
    check("t3_lives", lives, 1);
    check("t3_en_off", {player_en, aliens_en}, 0);
    measure(HIT, n);
    check("t3_hit_len", n, 12);
    check("t3_respawn", state, RESPAWN);
    measure(RESPAWN, n);
    check("t3_resp_len", n, 8);
    check("t3_play", state, PLAY);
    check("t3_prst", prst_cnt - p0, 1);
    check("t3_arst", arst_cnt - a0, 0);
    player_hit = 1'b1; step(); player_hit = 1'b0;
    check("t3_hit2_lives", lives, 0);
    measure(HIT, n);
    check("t3_hit2_len", n, 12);
    check("t3_over", state, OVER);
    check("t3_over_score", score, 30);
    check("t3_over_wave", wave, 1);

    // 4: hit together with the final kill
    press();
    check("t4_title", state, TITLE);
    press();
    check("t4_play", state, PLAY);
    check("t4_wave0", wave, 0);
    kill(); kill();
    player_hit = 1'b1; alien_killed = 1'b1; step();
    player_hit = 1'b0; alien_killed = 1'b0;
    check("t4_hit", state, HIT);
    check("t4_score", score, 30);
    check("t4_lives", lives, 1);
    measure(HIT, n);
    measure(RESPAWN, n);
    check("t4_play_again", state, PLAY);
    measure(PLAY, n);
    check("t4_play_len", n, 1);
    check("t4_wclr", state, WAVE_CLR);
    measure(WAVE_CLR, n);
    check("t4_wave", wave, 1);

    // 5: bottom beats hit; events ignored outside PLAY
    aliens_at_bottom = 1'b1; player_hit = 1'b1; step();
    aliens_at_bottom = 1'b0; player_hit = 1'b0;
    check("t5_over", state, OVER);
    check("t5_lives", lives, 0);
    kill();
    check("t5_over_ignore", score, 30);
    press();
    check("t5_title", state, TITLE);
    kill();
    check("t5_title_ignore", score, 30);

    // 6: async reset mid-HIT
    press();
    player_hit = 1'b1; step(); player_hit = 1'b0;
    repeat (5) step();
    check("t6_in_hit", state, HIT);
    rst_n = 1'b0;
    #1;
    check("t6_state", state, TITLE);
    check("t6_lives", lives, 0);
    check("t6_score", score, 0);
    check("t6_outs", {player_en, aliens_en, player_rst, aliens_rst}, 0);
    #1 rst_n = 1'b1;
    step();

    // saturation on the second instance
    btn2 = 1'b1; step(); btn2 = 1'b0;
    check("sat_play", state2, PLAY);
    check("sat_outs", {pen2, aen2, prst2, arst2}, 4'b1111);
    check("sat_lives", lives2, 2);
    kill2 = 1'b1; step(); kill2 = 1'b0;
    check("sat_first", score2, 16'hFFF0);
    kill2 = 1'b1; step(); kill2 = 1'b0;
    check("sat_clamp", score2, 16'hFFFF);
    kill2 = 1'b1; step(); kill2 = 1'b0;
    check("sat_hold", score2, 16'hFFFF);
    check("sat_wave", wave2, 0);

    check("pulse_width", wide_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
